// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the multicycle mips core. Holds the unified
// instruction/data word memory, a small MMIO page (LED register, free-running
// cycle counter, halt register) and a byte-stream boot loader that fills the
// memory while the core is held in reset.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   dataadr     byte address from the core
//   writedata   store data from the core
//   memwrite    store strobe from the core
//   readdata    combinational read data to the core
//   load_valid  loader byte present
//   load_byte   loader byte
//   load_last   final loader byte (qualified by load_valid)
//   load_ready  loader can accept a byte this cycle
//   cpu_reset   active-high reset to the core (LOAD and HALT)
//   led         LED register
//   halted      program has written the halt register
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int N     = 32,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] dataadr,
    input  logic [N-1:0] writedata,
    input  logic         memwrite,
    output logic [N-1:0] readdata,
    input  logic         load_valid,
    input  logic [7:0]   load_byte,
    input  logic         load_last,
    output logic         load_ready,
    output logic         cpu_reset,
    output logic [7:0]   led,
    output logic         halted
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;

    logic [AW-1:0]  ptr_reg;
    logic [1:0]     cnt_reg;
    logic [23:0]    asm_reg;        // lower three byte lanes of the word in flight
    logic [N-1:0]   cycle_reg;
    logic [7:0]     led_reg;

    logic [N-1:0]   mem [DEPTH];

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic           mmio_sel;
    logic [1:0]     mmio_off;
    logic [AW-1:0]  mem_idx;

    assign mmio_sel = (dataadr[N-1 -: 4] == 4'hF);
    assign mmio_off = dataadr[3:2];
    assign mem_idx  = dataadr[AW+1:2];

    // Byte offset and the bits between the word index and the MMIO nibble
    // do not take part in decode.
    logic unused_bits;
    assign unused_bits = ^{dataadr[1:0], dataadr[N-5:AW+2]};

    // -----------------------------------------------------------------------
    // Core-side write qualification (stores only count while running)
    // -----------------------------------------------------------------------
    logic cpu_we;
    logic mem_we_cpu;
    logic led_we;
    logic halt_req;

    assign cpu_we     = (state_reg == ST_RUN) & memwrite;
    assign mem_we_cpu = cpu_we & ~mmio_sel;
    assign led_we     = cpu_we & mmio_sel & (mmio_off == 2'd0);
    assign halt_req   = cpu_we & mmio_sel & (mmio_off == 2'd2);

    // -----------------------------------------------------------------------
    // Loader
    // -----------------------------------------------------------------------
    logic        load_accept;
    logic        word_done;
    logic [31:0] load_word;

    assign load_accept = load_valid & load_ready;
    // A word is flushed on its fourth byte or on the last byte of the stream.
    assign word_done   = load_accept & ((cnt_reg == 2'd3) | load_last);

    // The incoming byte lands in the lane selected by the byte count; lanes
    // above it are still zero from the previous flush, so a short final word
    // is zero-extended for free.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign load_word[gi*8 +: 8] = (cnt_reg == 2'(gi)) ? load_byte
                                                               : asm_reg[gi*8 +: 8];
        end
    endgenerate
    assign load_word[31:24] = (cnt_reg == 2'd3) ? load_byte : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg <= '0;
            cnt_reg <= 2'd0;
            asm_reg <= '0;
        end else if (word_done) begin
            ptr_reg <= ptr_reg + AW'(1);
            cnt_reg <= 2'd0;
            asm_reg <= '0;
        end else if (load_accept) begin
            cnt_reg <= cnt_reg + 2'd1;
            for (int i = 0; i < 3; i++) begin
                if (cnt_reg == 2'(i)) begin
                    asm_reg[i*8 +: 8] <= load_byte;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Word memory: one write port shared by loader and core. The two sources
    // are active in mutually exclusive states, so a plain mux suffices.
    // Contents survive reset.
    // -----------------------------------------------------------------------
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;

    always_comb begin
        wr_en   = word_done | mem_we_cpu;
        wr_addr = mem_idx;
        wr_data = writedata;
        if (word_done) begin
            wr_addr = ptr_reg;
            wr_data = N'(load_word);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // MMIO registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_reg <= 8'h00;
        end else if (led_we) begin
            led_reg <= writedata[7:0];
        end
    end

    // Counts every RUN edge, including the one that moves to HALT; frozen after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            cycle_reg <= cycle_reg + N'(1);
        end
    end

    assign led = led_reg;

    // -----------------------------------------------------------------------
    // Read path: fully combinational in every state
    // -----------------------------------------------------------------------
    always_comb begin
        readdata = mem[mem_idx];
        if (mmio_sel) begin
            case (mmio_off)
                2'd0:    readdata = {{(N-8){1'b0}}, led_reg};
                2'd1:    readdata = cycle_reg;
                2'd2:    readdata = {{(N-1){1'b0}}, halted};
                default: readdata = '0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD: if (load_accept & load_last) state_next = ST_RUN;
            ST_RUN:  if (halt_req)                state_next = ST_HALT;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_LOAD;
        endcase
    end

    always_comb begin
        load_ready = 1'b0;
        cpu_reset  = 1'b1;
        halted     = 1'b0;
        case (state_reg)
            ST_LOAD: load_ready = 1'b1;
            ST_RUN:  cpu_reset  = 1'b0;
            ST_HALT: halted     = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int N     = 32;
    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] dataadr = '0;
    logic [N-1:0] writedata = '0;
    logic         memwrite = 1'b0;
    logic [N-1:0] readdata;
    logic         load_valid = 1'b0;
    logic [7:0]   load_byte = 8'h00;
    logic         load_last = 1'b0;
    logic         load_ready;
    logic         cpu_reset;
    logic [7:0]   led;
    logic         halted;

    mem_responder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .memwrite   (memwrite),
        .readdata   (readdata),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_reset  (cpu_reset),
        .led        (led),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: phase, byte queue, word array with known flags
    // ---------------------------------------------------------------------
    typedef enum {M_LOAD, M_RUN, M_HALT} mphase_t;
    typedef logic [7:0] bq_t[$];

    mphase_t     m_ph = M_LOAD;
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    logic [7:0]  m_q[$];
    int          m_ptr = 0;
    logic [31:0] m_cnt = 0;
    logic [7:0]  m_led = 0;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit ok);
        ok = 1'b1;
        if (a[31:28] == 4'hF) begin
            case (a[3:2])
                2'd0:    return {24'b0, m_led};
                2'd1:    return m_cnt;
                2'd2:    return {31'b0, (m_ph == M_HALT)};
                default: return 32'h0;
            endcase
        end
        ok = m_known[widx(a)];
        return m_mem[widx(a)];
    endfunction

    task automatic model_reset();
        m_ph  = M_LOAD;
        m_q.delete();
        m_ptr = 0;
        m_cnt = 0;
        m_led = 0;
    endtask

    task automatic model_edge();
        logic [31:0] w;
        case (m_ph)
            M_LOAD: begin
                if (load_valid) begin
                    m_q.push_back(load_byte);
                    if (m_q.size() == 4 || load_last) begin
                        w = 0;
                        foreach (m_q[i]) w = w + (32'(m_q[i]) << (8 * i));
                        m_mem[m_ptr]   = w;
                        m_known[m_ptr] = 1'b1;
                        m_ptr = (m_ptr + 1) % DEPTH;
                        m_q.delete();
                        if (load_last) m_ph = M_RUN;
                    end
                end
            end
            M_RUN: begin
                m_cnt = m_cnt + 32'd1;
                if (memwrite) begin
                    if (dataadr[31:28] == 4'hF) begin
                        if (dataadr[3:2] == 2'd0) m_led = writedata[7:0];
                        else if (dataadr[3:2] == 2'd2) m_ph = M_HALT;
                    end else begin
                        m_mem[widx(dataadr)]   = writedata;
                        m_known[widx(dataadr)] = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_model();
        bit ok;
        logic [31:0] exp_rd;
        exp_rd = m_read(dataadr, ok);
        chk("m_load_ready", {31'b0, load_ready}, {31'b0, m_ph == M_LOAD});
        chk("m_cpu_reset",  {31'b0, cpu_reset},  {31'b0, m_ph != M_RUN});
        chk("m_halted",     {31'b0, halted},     {31'b0, m_ph == M_HALT});
        chk("m_led",        {24'b0, led},        {24'b0, m_led});
        if (ok) chk("m_readdata", readdata, exp_rd);
    endtask

    // Inputs change at the falling edge; outputs are sampled 2 ns later.
    task automatic set_in(input logic lv, input logic [7:0] lb, input logic ll,
                          input logic mw, input logic [31:0] adr, input logic [31:0] wd);
        load_valid = lv;
        load_byte  = lb;
        load_last  = ll;
        memwrite   = mw;
        dataadr    = adr;
        writedata  = wd;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_in(0, 8'h00, 0, 0, 32'h0, 32'h0);
        model_reset();
        chk("rst_cpu_reset",  {31'b0, cpu_reset},  32'd1);
        chk("rst_load_ready", {31'b0, load_ready}, 32'd1);
        chk("rst_halted",     {31'b0, halted},     32'd0);
        chk("rst_led",        {24'b0, led},        32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_bytes(input bq_t bs);
        foreach (bs[i]) begin
            set_in(1, bs[i], (i == bs.size() - 1), 0, 32'h0, 32'h0);
            chk("ld_ready", {31'b0, load_ready}, 32'd1);
            chk("ld_cpu_reset", {31'b0, cpu_reset}, 32'd1);
            tick();
        end
    endtask

    function automatic logic [31:0] rand_mem_adr();
        logic [31:0] a;
        a = ($urandom & 32'h0FFF_FC00) | (32'($urandom_range(0, 31)) << 2)
            | 32'($urandom_range(0, 3));
        a[31:28] = 4'($urandom_range(0, 14));
        return a;
    endfunction

    // ---------------------------------------------------------------------
    // Directed tables
    // ---------------------------------------------------------------------
    typedef struct {
        logic [7:0] b;
        logic       last;
    } ld_t;

    typedef struct {
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] rd;
        logic [7:0]  led;
        logic        hlt;
    } run_t;

    ld_t  ld_tab [8];
    run_t run_tab [18];

    initial begin
        bq_t q;
        ld_tab = '{
            '{8'h11, 0}, '{8'h22, 0}, '{8'h33, 0}, '{8'h44, 0},
            '{8'h55, 0}, '{8'h66, 0}, '{8'h77, 0}, '{8'h88, 1}
        };
        // Row index == RUN cycle index (counter reads that value).
        run_tab = '{
            '{0, 32'h0000_0000, 32'h0,          1, 32'h4433_2211, 8'h00, 0},
            '{0, 32'h0000_0004, 32'h0,          1, 32'h8877_6655, 8'h00, 0},
            '{1, 32'h0000_0040, 32'hDEAD_BEEF,  0, 32'h0,         8'h00, 0},
            '{0, 32'h0000_0040, 32'h0,          1, 32'hDEAD_BEEF, 8'h00, 0},
            '{0, 32'h0000_0043, 32'h0,          1, 32'hDEAD_BEEF, 8'h00, 0},
            '{0, 32'h0000_0440, 32'h0,          1, 32'hDEAD_BEEF, 8'h00, 0},
            '{1, 32'hF000_0000, 32'h0000_01A5,  1, 32'h0,         8'h00, 0},
            '{0, 32'hF000_0000, 32'h0,          1, 32'h0000_00A5, 8'hA5, 0},
            '{0, 32'hF000_000C, 32'h0,          1, 32'h0,         8'hA5, 0},
            '{1, 32'hF000_0004, 32'h1234_5678,  1, 32'd9,         8'hA5, 0},
            '{0, 32'hF000_0004, 32'h0,          1, 32'd10,        8'hA5, 0},
            '{0, 32'hF000_0008, 32'h0,          1, 32'd0,         8'hA5, 0},
            '{1, 32'hF000_0008, 32'h1,          1, 32'd0,         8'hA5, 0},
            '{0, 32'hF000_0004, 32'h0,          1, 32'd13,        8'hA5, 1},
            '{1, 32'h0000_0040, 32'h0,          1, 32'hDEAD_BEEF, 8'hA5, 1},
            '{0, 32'h0000_0040, 32'h0,          1, 32'hDEAD_BEEF, 8'hA5, 1},
            '{0, 32'hF000_0008, 32'h0,          1, 32'd1,         8'hA5, 1},
            '{0, 32'hF000_0004, 32'h0,          1, 32'd13,        8'hA5, 1}
        };

        @(negedge clk);
        do_reset();

        // Boot load 11..88, then the RUN/HALT table.
        foreach (ld_tab[i]) begin
            set_in(1, ld_tab[i].b, ld_tab[i].last, 0, 32'h0, 32'h0);
            chk("tab_ld_ready", {31'b0, load_ready}, 32'd1);
            chk("tab_ld_cpu_reset", {31'b0, cpu_reset}, 32'd1);
            check_model();
            tick();
        end
        foreach (run_tab[i]) begin
            set_in(0, 8'h00, 0, run_tab[i].mw, run_tab[i].adr, run_tab[i].wd);
            if (run_tab[i].chk_rd) chk($sformatf("tab_rd[%0d]", i), readdata, run_tab[i].rd);
            chk($sformatf("tab_led[%0d]", i), {24'b0, led}, {24'b0, run_tab[i].led});
            chk($sformatf("tab_halted[%0d]", i), {31'b0, halted}, {31'b0, run_tab[i].hlt});
            chk($sformatf("tab_cpu_reset[%0d]", i), {31'b0, cpu_reset}, {31'b0, run_tab[i].hlt});
            chk($sformatf("tab_load_ready[%0d]", i), {31'b0, load_ready}, 32'd0);
            check_model();
            tick();
        end

        // Partial final word is zero-extended.
        do_reset();
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        load_bytes(q);
        set_in(0, 8'h00, 0, 0, 32'h0000_0000, 32'h0);
        chk("part_word0", readdata, 32'hDDCC_BBAA);
        chk("part_run", {31'b0, cpu_reset}, 32'd0);
        tick();
        set_in(0, 8'h00, 0, 0, 32'h0000_0004, 32'h0);
        chk("part_word1", readdata, 32'h0000_00EE);
        tick();

        // Reset in the middle of a word discards it and restarts at word 0.
        do_reset();
        q = '{8'h55, 8'h66};
        foreach (q[i]) begin
            set_in(1, q[i], 0, 0, 32'h0, 32'h0);
            tick();
        end
        do_reset();
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        load_bytes(q);
        set_in(0, 8'h00, 0, 0, 32'h0000_0000, 32'h0);
        chk("mid_word0", readdata, 32'h0403_0201);
        chk("mid_led", {24'b0, led}, 32'd0);
        chk("mid_run", {31'b0, cpu_reset}, 32'd0);
        chk("mid_ready", {31'b0, load_ready}, 32'd0);
        tick();
        set_in(0, 8'h00, 0, 0, 32'h0000_0004, 32'h0);
        chk("mid_word1_kept", readdata, 32'h0000_00EE);
        tick();

        // Randomized sessions against the model.
        for (int it = 0; it < 8; it++) begin
            int n, sent, guard;
            do_reset();
            n = $urandom_range(1, 24);
            sent = 0;
            guard = 0;
            while (sent < n && guard < 200) begin
                logic lv;
                lv = ($urandom_range(0, 3) != 0);
                set_in(lv, 8'($urandom), lv && (sent == n - 1), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 1) != 0) ? 32'hF000_0008 : rand_mem_adr(), $urandom);
                check_model();
                tick();
                if (lv) sent++;
                guard++;
            end
            if (guard >= 200) chk("rand_load_budget", 32'(guard), 32'd0);
            for (int c = 0; c < $urandom_range(20, 60); c++) begin
                int op;
                logic [31:0] adr;
                logic mw;
                op = $urandom_range(0, 99);
                mw = 1'b0;
                if (op < 55) begin
                    adr = rand_mem_adr();
                end else if (op < 70) begin
                    adr = rand_mem_adr();
                    mw = 1'b1;
                end else begin
                    adr = 32'hF000_0000 | (32'($urandom_range(0, 3)) << 2);
                    mw = (op >= 90);
                end
                set_in(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                       mw, adr, $urandom);
                check_model();
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle `mips` core's bus (`dataadr`, `writedata`, `memwrite`, `readdata`). It holds the unified instruction/data word memory and a small MMIO page (LED register, cycle counter, halt register). It also contains a byte-stream boot loader that fills memory while holding the core in reset, then releases it. It sits at the top level beside `mips` and drives that core's active-high reset.

## Interface
Parameters:
- `N`, 32, bus data/address width
- `DEPTH`, 256, memory size in words (power of two); `AW = log2(DEPTH)`

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `dataadr`  in  N  byte address from core
- `writedata`  in  N  store data from core
- `memwrite`  in  1  store strobe from core
- `readdata`  out  N  read data to core
- `load_valid`  in  1  loader byte present
- `load_byte`  in  8  loader byte
- `load_last`  in  1  marks final loader byte (qualified by `load_valid`)
- `load_ready`  out  1  loader can accept a byte this cycle
- `cpu_reset`  out  1  active-high reset to `mips`
- `led`  out  8  LED register
- `halted`  out  1  program has written the halt register

## Operation
- FSM states: LOAD, RUN, HALT.
  - Reset enters LOAD.
  - LOAD goes to RUN on the edge that accepts a byte with `load_last=1`.
  - RUN goes to HALT on a `memwrite` to the halt address.
  - HALT is left only by reset.
- Outputs per state:
  - `load_ready` = 1 only in LOAD.
  - `cpu_reset` = 1 in LOAD and HALT.
  - `halted` = 1 only in HALT.
- Loader:
  - A byte is accepted when `load_valid & load_ready`.
  - Bytes are assembled little-endian: 1st byte goes to [7:0], 4th to [31:24].
  - On the 4th byte, the word is written to `mem[ptr]`, then `ptr` increments and the byte count clears.
  - `ptr` wraps from DEPTH-1 to 0.
  - If `load_last` arrives with a partial word, the unreceived upper bytes are written as zero.
- Address decode:
  - `dataadr[31:28]==4'hF` selects MMIO.
  - Otherwise the word index is `dataadr[AW+1:2]`. Bits [1:0] and the unused upper bits are ignored.
- Memory behaviour:
  - Read is asynchronous: `readdata` is `mem[index]` combinationally.
  - Write is synchronous on the edge with `memwrite=1`, as a full word.
- MMIO map (word offset in `dataadr[3:2]`):
  - `0xF0000000` LED: reads `{24'b0, led}`; a write loads `writedata[7:0]`.
  - `0xF0000004` cycle counter: read-only; writes are ignored.
  - `0xF0000008` halt: reads `{31'b0, halted}`; any write causes RUN→HALT.
  - `0xF000000C` reads 0; writes are ignored.
- Gating:
  - `memwrite` is honoured only in RUN.
  - In LOAD/HALT, `readdata` still follows decode combinationally.
  - `load_valid` is ignored outside LOAD.
- Cycle counter: N-bit, increments on every edge where state==RUN (including the edge entering HALT), and wraps modulo 2^N.
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - state LOAD; `cpu_reset`=1, `load_ready`=1, `halted`=0, `led`=0
  - counter=0, `ptr`=0, byte count=0, assembly register=0
- Reset mid-load discards any partial word and restarts at `ptr`=0. Words already written remain.
- Loader throughput: one byte per cycle, zero-bubble. The word write occurs on the same edge as the byte that completes it.
- `cpu_reset` falls in the cycle after the `load_last` byte is accepted. That byte's word is already in memory at that point.
- The counter reads 0 in the first RUN cycle. A read returns the pre-increment value.
- A store is visible to a read of the same address in the following cycle.
- A halt write causes `cpu_reset`=1 and `halted`=1 in the next cycle, and the counter freezes.

## Test plan
- Reset, then load bytes 11,22,…,88 on consecutive cycles with `load_last` on 88:
  - `mem[0]=0x44332211` and `mem[1]=0x88776655`.
  - `cpu_reset` and `load_ready` drop the next cycle.
- Load AA,BB,CC,DD,EE (last on EE) → `mem[1]=0x000000EE`.
- In RUN, store `0xDEADBEEF` to `0x40`:
  - Next cycle, reading `0x40` or `0x43` returns `0xDEADBEEF`.
  - Reading `0x440` (DEPTH=256) also aliases to it.
- Store `0x000001A5` to `0xF0000000` → `led=0xA5`, and the readback is `0x000000A5`. A counter read exactly 10 cycles after RUN entry returns 10.
- Store to `0xF0000008`:
  - Next cycle `halted=1`, `cpu_reset=1`, and the counter stays constant.
  - A later store to `0x40` is ignored.
- Assert `reset` low after 2 loader bytes, release it, then load 4 bytes 01,02,03,04 with last:
  - `mem[0]=0x04030201`.
  - `led=0`.
  - RUN is entered.
